bypass_sdp_ram: RTL and testbench

Parametrised simple-dual-port RAM (one write port, one read port) with byte write enables, selectable read latency, write-to-read collision bypass and a hardware clear sweep. It replaces the bare dual-port macro wrappers under cache tag/valid arrays and predictor tables. Those arrays must start and restart from a known value, and must return write-first data on same-cycle collisions.

---
 rtl/ram_pkg.sv | 14 +
 rtl/sdp_ram_core.sv | 38 +++
 rtl/bypass_sdp_ram.sv | 171 +++++++++++++++++
 tb/tb_bypass_sdp_ram.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and parameter checks for the bypass simple-dual-port RAM.
package ram_pkg;

  typedef enum logic {
    RAM_INIT  = 1'b0,
    RAM_READY = 1'b1
  } ram_state_t;

  // Only one- and two-cycle read pipelines are implemented.
  function automatic bit latency_legal(input int unsigned lat);
    return (lat == 32'd1) || (lat == 32'd2);
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Behavioural byte-enable simple-dual-port array, read-first registered read port.
module sdp_ram_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned BYTE_WIDTH = 8,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned NB        = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [NB-1:0]         wbe_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset on the array so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe_i[i]) begin
          mem_q[waddr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bypass_sdp_ram.sv
// SDP RAM wrapper: clear-sweep FSM, write-first collision bypass and optional
// output register around a read-first array core.
module bypass_sdp_ram
  import ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 128,
  parameter int unsigned           BYTE_WIDTH = 8,
  parameter int unsigned           LATENCY    = 1,
  parameter bit                    INIT_CLEAR = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned          ADDR_W     = $clog2(DEPTH),
  localparam int unsigned          NB         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  init_done,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [NB-1:0]         wbe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("bypass_sdp_ram: LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("bypass_sdp_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  localparam ram_state_t RST_STATE = INIT_CLEAR ? RAM_INIT : RAM_READY;

  ram_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;

  logic                  wr_acc_c, rd_acc_c;
  logic                  core_we_c;
  logic [ADDR_W-1:0]     core_waddr_c;
  logic [NB-1:0]         core_wbe_c;
  logic [DATA_WIDTH-1:0] core_wdata_c;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic [NB-1:0]         byp_mask_q, byp_mask_d;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic                  rvalid1_q;
  logic [DATA_WIDTH-1:0] merged_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= !INIT_CLEAR;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Sweep owns the write port in INIT; user traffic only passes in READY without clear.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_acc_c     = 1'b0;
    rd_acc_c     = 1'b0;
    core_we_c    = 1'b0;
    core_waddr_c = waddr;
    core_wbe_c   = wbe;
    core_wdata_c = wdata;
    unique case (state_q)
      RAM_INIT: begin
        core_we_c    = 1'b1;
        core_waddr_c = cnt_q;
        core_wbe_c   = '1;
        core_wdata_c = INIT_VALUE;
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RAM_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RAM_READY: begin
        if (clear) begin
          state_d = RAM_INIT;
          cnt_d   = '0;
        end else begin
          wr_acc_c  = wen;
          rd_acc_c  = ren;
          core_we_c = wen;
        end
      end
    endcase
    init_done_d = (state_d == RAM_READY);
  end

  assign init_done = init_done_q;

  sdp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_core (
    .clk     (clk),
    .we_i    (core_we_c),
    .waddr_i (core_waddr_c),
    .wbe_i   (core_wbe_c),
    .wdata_i (core_wdata_c),
    .re_i    (rd_acc_c),
    .raddr_i (raddr),
    .rdata_o (core_rdata)
  );

  assign byp_mask_d = (wr_acc_c && (waddr == raddr)) ? wbe : '0;

  // All-ones mask with zero data forces rdata to 0 out of reset despite the unreset core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_mask_q <= '1;
      byp_data_q <= '0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid1_q <= rd_acc_c;
      if (rd_acc_c) begin
        byp_mask_q <= byp_mask_d;
        byp_data_q <= wdata;
      end
    end
  end

  always_comb begin
    merged_c = core_rdata;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byp_mask_q[i]) begin
        merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q   <= '0;
        rvalid2_q <= 1'b0;
      end else begin
        rvalid2_q <= rvalid1_q;
        if (rvalid1_q) begin
          rdata_q <= merged_c;
        end
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid2_q;
  end else begin : g_lat1
    assign rdata  = merged_c;
    assign rvalid = rvalid1_q;
  end

endmodule

// File: tb/tb_bypass_sdp_ram.sv
// Drives LATENCY=1 and LATENCY=2 instances in lockstep against an array/queue model.
module tb_bypass_sdp_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned NB    = 4;
  localparam logic [DW-1:0] IV  = 32'hA5A5_A5A5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          wen   = 1'b0;
  logic          ren   = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [NB-1:0] wbe   = '0;
  logic [DW-1:0] wdata = '0;

  logic [1:0]    init_done_w;
  logic [1:0]    rvalid_w;
  logic [DW-1:0] rdata_w [2];

  always #5 clk = ~clk;

  bypass_sdp_ram #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(8), .LATENCY(1),
    .INIT_CLEAR(1'b1), .INIT_VALUE(IV)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .init_done(init_done_w[0]),
    .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata_w[0]), .rvalid(rvalid_w[0])
  );

  bypass_sdp_ram #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(8), .LATENCY(2),
    .INIT_CLEAR(1'b1), .INIT_VALUE(IV)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .init_done(init_done_w[1]),
    .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata_w[1]), .rvalid(rvalid_w[1])
  );

  // Reference model: plain array plus a log of read results with their sample cycle.
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  bit            ready_m;
  int            sweep_left;
  rd_t           rd_log[$];
  int            rp [2];
  logic [DW-1:0] last_m [2];
  int            cyc;
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic enter_init();
    ready_m    = 1'b0;
    sweep_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = IV;
  endtask

  task automatic model_reset();
    enter_init();
    for (int l = 0; l < 2; l++) begin
      rp[l]     = rd_log.size();
      last_m[l] = '0;
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (!ready_m) begin
      if (clear) sweep_left = DEPTH;
      else begin
        sweep_left--;
        if (sweep_left == 0) ready_m = 1'b1;
      end
    end else if (clear) begin
      enter_init();
    end else begin
      if (wen) begin
        for (int i = 0; i < NB; i++)
          if (wbe[i]) mem_m[waddr][i*8 +: 8] = wdata[i*8 +: 8];
      end
      if (ren) rd_log.push_back('{cyc, mem_m[raddr]});
    end
  endtask

  task automatic check_outputs();
    for (int l = 0; l < 2; l++) begin
      logic          exp_rv;
      logic [DW-1:0] exp_rd;
      exp_rv = 1'b0;
      exp_rd = last_m[l];
      if (rp[l] < rd_log.size() && rd_log[rp[l]].cyc + l == cyc) begin
        exp_rv    = 1'b1;
        exp_rd    = rd_log[rp[l]].data;
        last_m[l] = exp_rd;
        rp[l]++;
      end
      chk($sformatf("init_done_L%0d@%0d", l + 1, cyc), DW'(init_done_w[l]), DW'(ready_m));
      chk($sformatf("rvalid_L%0d@%0d", l + 1, cyc), DW'(rvalid_w[l]), DW'(exp_rv));
      chk($sformatf("rdata_L%0d@%0d", l + 1, cyc), rdata_w[l], exp_rd);
    end
  endtask

  task automatic step(input logic c, input logic we, input logic [AW-1:0] wa,
                      input logic [NB-1:0] be, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra);
    @(negedge clk);
    clear = c; wen = we; waddr = wa; wbe = be; wdata = wd; ren = re; raddr = ra;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    step(1'b0, 1'b1, a, be, d, 1'b0, '0);
  endtask

  // Asynchronous reset between edges, then a release away from any edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rd_log.delete();
    model_reset();

    #1 rst_n = 1'b0;
    #1 check_outputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Power-up sweep, then every address should hold the init value.
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    idle(2);

    // Same-cycle collision, partial lanes.
    wr(AW'(3), 4'hF, 32'h1111_1111);
    step(1'b0, 1'b1, AW'(3), 4'b0101, 32'hFFFF_FFFF, 1'b1, AW'(3));
    chk("collision_L1", rdata_w[0], 32'h11FF_11FF);
    idle(1);
    chk("collision_L2", rdata_w[1], 32'h11FF_11FF);
    idle(1);

    // A write in the cycle after a read is not visible to that read.
    wr(AW'(5), 4'hF, 32'h5555_0000);
    rd(AW'(5));
    wr(AW'(5), 4'hF, 32'hDEAD_BEEF);
    idle(2);

    // Back-to-back reads 0..7 after filling with distinct data.
    for (int a = 0; a < 8; a++) wr(AW'(a), 4'hF, 32'h0100_0000 * a + 32'(a));
    for (int a = 0; a < 8; a++) rd(AW'(a));
    idle(2);

    // Randomised traffic, with occasional clears and frequent collisions.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      step(($urandom_range(0, 59) == 0), 1'($urandom), wa, NB'($urandom),
           $urandom, 1'($urandom), ra);
    end
    idle(DEPTH + 2);

    // Read in flight across a clear, clear drops a same-cycle write, addr 2 returns init.
    wr(AW'(2), 4'hF, 32'h2222_2222);
    rd(AW'(2));
    step(1'b1, 1'b1, AW'(2), 4'hF, 32'h7777_7777, 1'b1, AW'(2));
    idle(DEPTH);
    rd(AW'(2));
    idle(2);

    // Reset in the middle of a clear sweep (cnt = 7).
    rd(AW'(3));
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    idle(7);
    mid_reset();
    idle(DEPTH);
    for (int a = 0; a < 4; a++) rd(AW'(a));
    idle(2);

    // A read still in the LATENCY=2 pipeline when reset hits yields no rvalid.
    wr(AW'(1), 4'hF, 32'hCAFE_F00D);
    rd(AW'(1));
    mid_reset();
    idle(DEPTH + 2);
    rd(AW'(1));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
